// File: rtl/mash_decimator.sv
// Boxcar (sinc1) accumulate-and-dump decimator for a MASH modulator's dn stream.
// Optional feature macro: MASH_DEC_RANGE_CHECK_EN adds a sticky 4th-order dn range flag.
module mash_decimator #(
  parameter  int WIN_LOG2 = 8,
  parameter  int DN_W     = 5,
  localparam int ACC_W    = WIN_LOG2 + DN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             dn_valid,
  input  logic [DN_W-1:0]  dn,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic             dn_range_err
);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [WIN_LOG2-1:0] count_q, count_d;
  logic [ACC_W-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]    dn_ext;
  logic [ACC_W-1:0]    win_sum;
  logic                last_sample;
  logic                slot_free;

  // ACC_W = WIN_LOG2 + DN_W bits hold 2**WIN_LOG2 worst-case samples, so no overflow.
  assign dn_ext      = {{WIN_LOG2{dn[DN_W-1]}}, dn};
  assign win_sum     = acc_q + dn_ext;
  assign last_sample = &count_q;

  // Output handshake: a result transfers on a cycle where out_valid && out_ready;
  // out_data is stable while out_valid && !out_ready, and the slot counts as free
  // when it is empty or being consumed in the same cycle.
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      acc_d       = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_ovf_d   = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (dn_valid) begin
        if (last_sample) begin
          acc_d   = '0;
          count_d = '0;
          if (slot_free) begin
            out_data_d  = win_sum;
            out_valid_d = 1'b1;
          end else begin
            out_ovf_d = 1'b1;
          end
        end else begin
          acc_d   = win_sum;
          count_d = count_q + WIN_LOG2'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;

`ifdef MASH_DEC_RANGE_CHECK_EN
  // A 4th-order MASH only ever produces dn in [-7, +8]; the sample is still summed.
  localparam logic signed [ACC_W-1:0] RANGE_MIN = ACC_W'(-7);
  localparam logic signed [ACC_W-1:0] RANGE_MAX = ACC_W'(8);

  logic range_err_q, range_err_d;
  logic dn_out_of_range;

  assign dn_out_of_range = ($signed(dn_ext) < RANGE_MIN) || ($signed(dn_ext) > RANGE_MAX);

  always_comb begin
    range_err_d = range_err_q;
    if (clear) begin
      range_err_d = 1'b0;
    end else if (dn_valid && dn_out_of_range) begin
      range_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
    end else begin
      range_err_q <= range_err_d;
    end
  end

  assign dn_range_err = range_err_q;
`else
  assign dn_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mash_decimator.sv
// Directed bench for mash_decimator with WIN_LOG2=4: window sums, gaps, backpressure,
// overflow, clear, async reset and (when MASH_DEC_RANGE_CHECK_EN is defined) the range flag.
module tb_mash_decimator;

  localparam int WIN_LOG2 = 4;
  localparam int DN_W     = 5;
  localparam int ACC_W    = WIN_LOG2 + DN_W;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             dn_valid;
  logic [DN_W-1:0]  dn;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_ovf;
  logic             dn_range_err;

  int checks_total;
  int checks_passed;
  logic [31:0] exp_q[$];

  mash_decimator #(
    .WIN_LOG2(WIN_LOG2),
    .DN_W    (DN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .dn_valid    (dn_valid),
    .dn          (dn),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ovf     (out_ovf),
    .dn_range_err(dn_range_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(obs), obs,
               $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] data_s();
    return 32'($signed(out_data));
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int val);
    dn_valid = 1'b1;
    dn       = DN_W'(val);
    step();
    dn_valid = 1'b0;
    dn       = DN_W'($urandom_range(0, 31));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dn_valid = 1'b0;
      dn       = DN_W'($urandom_range(0, 31));
      step();
    end
  endtask

  task automatic run_window(input int val, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send(val);
      if (gap > 0) idle(gap);
    end
  endtask

  // Scoreboard: every accepted result must match the next expected window sum
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_accept", {31'd0, out_valid}, 32'd0);
      end else begin
        check("sb_data", data_s(), exp_q.pop_front());
      end
    end
  end

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    dn_valid  = 1'b0;
    dn        = '0;
    out_ready = 1'b1;
    #12;
    check("rst_data", data_s(), 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ovf", {31'd0, out_ovf}, 32'd0);
    check("rst_range", {31'd0, dn_range_err}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: sixteen +1 samples
    exp_q.push_back(32'd16);
    run_window(1, 15, 0);
    check("t1_valid_early", {31'd0, out_valid}, 32'd0);
    send(1);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data", data_s(), 32'd16);
    idle(1);
    check("t1_valid_drop", {31'd0, out_valid}, 32'd0);

    // 2: negative samples, then alternating 0/1
    exp_q.push_back(-32'sd48);
    run_window(-3, 16, 0);
    check("t2_neg_data", data_s(), -32'sd48);
    exp_q.push_back(32'd8);
    for (int i = 0; i < 16; i++) send(i % 2);
    check("t2_alt_valid", {31'd0, out_valid}, 32'd1);
    check("t2_alt_data", data_s(), 32'd8);
    idle(1);

    // 3: dn_valid one cycle in three; garbage dn on gaps
    exp_q.push_back(32'd32);
    run_window(2, 15, 2);
    check("t3_valid_early", {31'd0, out_valid}, 32'd0);
    send(2);
    check("t3_data", data_s(), 32'd32);
    idle(1);

    // 4: backpressure across two windows
    out_ready = 1'b0;
    exp_q.push_back(32'd16);
    run_window(1, 16, 0);
    check("t4_first_valid", {31'd0, out_valid}, 32'd1);
    check("t4_first_ovf", {31'd0, out_ovf}, 32'd0);
    run_window(2, 16, 0);
    check("t4_held_data", data_s(), 32'd16);
    check("t4_held_valid", {31'd0, out_valid}, 32'd1);
    check("t4_ovf", {31'd0, out_ovf}, 32'd1);
    out_ready = 1'b1;
    idle(1);
    check("t4_accept_valid", {31'd0, out_valid}, 32'd0);
    check("t4_ovf_sticky", {31'd0, out_ovf}, 32'd1);

    // 5: clear mid-window, the clear-cycle sample is lost
    run_window(1, 7, 0);
    clear    = 1'b1;
    dn_valid = 1'b1;
    dn       = DN_W'(1);
    step();
    clear    = 1'b0;
    dn_valid = 1'b0;
    check("t5_clear_ovf", {31'd0, out_ovf}, 32'd0);
    check("t5_clear_valid", {31'd0, out_valid}, 32'd0);
    check("t5_clear_data_held", data_s(), 32'd16);
    exp_q.push_back(32'd16);
    run_window(1, 15, 0);
    check("t5_valid_early", {31'd0, out_valid}, 32'd0);
    send(1);
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    check("t5_data", data_s(), 32'd16);
    check("t5_ovf", {31'd0, out_ovf}, 32'd0);
    idle(1);

    // 5b: async reset mid-window with a held result and ovf set
    out_ready = 1'b0;
    run_window(3, 16, 0);
    run_window(1, 16, 0);
    run_window(1, 5, 0);
    check("t5b_pre_data", data_s(), 32'd48);
    check("t5b_pre_ovf", {31'd0, out_ovf}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5b_rst_data", data_s(), 32'd0);
    check("t5b_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5b_rst_ovf", {31'd0, out_ovf}, 32'd0);
    exp_q.delete();
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    exp_q.push_back(32'd16);
    run_window(1, 15, 0);
    check("t5b_valid_early", {31'd0, out_valid}, 32'd0);
    send(1);
    check("t5b_data", data_s(), 32'd16);
    idle(1);

    // 6: out-of-range sample still summed; legal extremes do not flag
    exp_q.push_back(32'd24);
    send(9);
`ifdef MASH_DEC_RANGE_CHECK_EN
    check("t6_range_set", {31'd0, dn_range_err}, 32'd1);
`else
    check("t6_range_tied", {31'd0, dn_range_err}, 32'd0);
`endif
    run_window(1, 15, 0);
    check("t6_sum_incl_oor", data_s(), 32'd24);
    idle(1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t6_range_cleared", {31'd0, dn_range_err}, 32'd0);
    exp_q.push_back(32'd8);
    for (int i = 0; i < 8; i++) begin
      send(-7);
      send(8);
    end
    check("t6_range_legal", {31'd0, dn_range_err}, 32'd0);
    check("t6_edge_data", data_s(), 32'd8);
    idle(2);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
